// File: rtl/holosynth_audio_pkg.sv
// Shared audio definitions for the holosynth datapath: default sample and
// slot geometry, the stereo sample container handed from the synthesizer
// to the audio back end, and small helpers for slot decoding.
package holosynth_audio_pkg;

    localparam int AUD_BIT_DEPTH_DEF = 24;
    localparam int SLOT_BITS_DEF     = 32;
    localparam int BCLK_DIV_DEF      = 4;

    // Stereo sample as produced by the synthesizer at default depth.
    typedef struct packed {
        logic [AUD_BIT_DEPTH_DEF-1:0] left;
        logic [AUD_BIT_DEPTH_DEF-1:0] right;
    } stereo_sample_t;

    // Channel currently occupying the serial slot (matches LRCK level).
    typedef enum logic {
        CHAN_LEFT  = 1'b0,
        CHAN_RIGHT = 1'b1
    } chan_e;

    // True when slot position pos carries a sample bit; position 0 is the
    // I2S one-bit delay and positions past the sample depth are padding.
    function automatic logic slot_bit_active(input int pos, input int depth);
        return (pos >= 1) && (pos <= depth);
    endfunction

endpackage

// File: rtl/audio_i2s_tx_clk_gen.sv
// Bit-clock and word-clock generator for the I2S transmitter. Divides the
// audio clock into BCLK, counts bit periods across a stereo frame and
// exposes strobes for the BCLK falling edge and for the frame wrap.
module i2s_clk_gen #(
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 4
) (
    input  logic                            clk,
    input  logic                            reset_data,
    output logic                            fall,
    output logic                            frame_wrap,
    output logic [$clog2(2*SLOT_BITS)-1:0]  bit_cnt_nxt,
    output logic                            bclk,
    output logic                            lrck
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2*SLOT_BITS);

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_cnt_nxt_s;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [BIT_W-1:0] bit_cnt_nxt_s;
    logic             fall_s;
    logic             frame_wrap_s;
    logic             bclk_r;
    logic             lrck_r;

    // Next divider/bit counter values and the edge strobes derived from them.
    always_comb begin
        fall_s        = (div_cnt_r == DIV_W'(BCLK_DIV - 1));
        frame_wrap_s  = 1'b0;
        div_cnt_nxt_s = div_cnt_r;
        bit_cnt_nxt_s = bit_cnt_r;
        if (fall_s) begin
            div_cnt_nxt_s = {DIV_W{1'b0}};
            if (bit_cnt_r == BIT_W'(2*SLOT_BITS - 1)) begin
                bit_cnt_nxt_s = {BIT_W{1'b0}};
                frame_wrap_s  = 1'b1;
            end else begin
                bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
            end
        end else begin
            div_cnt_nxt_s = div_cnt_r + DIV_W'(1);
        end
    end

    // Counter state plus BCLK/LRCK registered from the next counter values,
    // so both clocks stay exactly aligned with the counters.
    always_ff @(posedge clk) begin
        if (reset_data) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            bclk_r    <= 1'b0;
            lrck_r    <= 1'b0;
        end else begin
            div_cnt_r <= div_cnt_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            bclk_r    <= (div_cnt_nxt_s >= DIV_W'(BCLK_DIV / 2));
            lrck_r    <= (bit_cnt_nxt_s >= BIT_W'(SLOT_BITS));
        end
    end

    assign fall        = fall_s;
    assign frame_wrap  = frame_wrap_s;
    assign bit_cnt_nxt = bit_cnt_nxt_s;
    assign bclk        = bclk_r;
    assign lrck        = lrck_r;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter for the codec DAC. Accepts stereo samples through a
// valid/ready holding register, moves them into a shadow register at each
// frame boundary and shifts the shadow out MSB first with the I2S one-bit
// delay. A frame that starts with nothing held replays the previous sample.
// Optional build macro: I2S_UNDERRUN_CNT_EN enables the saturating
// underrun counter; without it underrun_cnt reads constant zero.
module audio_i2s_tx
    import holosynth_audio_pkg::*;
#(
    parameter int AUD_BIT_DEPTH = AUD_BIT_DEPTH_DEF,
    parameter int SLOT_BITS     = SLOT_BITS_DEF,
    parameter int BCLK_DIV      = BCLK_DIV_DEF
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset_data,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT,
    output logic                     frame_start,
    output logic                     underrun,
    output logic [15:0]              underrun_cnt
);

    localparam int BIT_W = $clog2(2*SLOT_BITS);
    localparam int POS_W = $clog2(SLOT_BITS);

    typedef struct packed {
        logic [AUD_BIT_DEPTH-1:0] left;
        logic [AUD_BIT_DEPTH-1:0] right;
    } sample_pair_t;

    logic               fall_s;
    logic               frame_wrap_s;
    logic [BIT_W-1:0]   bit_cnt_nxt_s;

    sample_pair_t       in_pair_s;
    sample_pair_t       hold_r;
    sample_pair_t       hold_nxt_s;
    sample_pair_t       shadow_r;
    sample_pair_t       shadow_nxt_s;
    logic               hold_empty_r;
    logic               hold_empty_nxt_s;
    logic               frame_start_r;
    logic               frame_start_nxt_s;
    logic               underrun_r;
    logic               underrun_nxt_s;
    logic               dacdat_r;
    logic               dacdat_nxt_s;

    chan_e              chan_s;
    logic [POS_W-1:0]   pos_s;
    logic [POS_W-1:0]   idx_s;
    logic [AUD_BIT_DEPTH-1:0] chan_word_s;

    i2s_clk_gen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV)
    ) u_clk_gen (
        .clk         (AUDIO_CLK),
        .reset_data  (reset_data),
        .fall        (fall_s),
        .frame_wrap  (frame_wrap_s),
        .bit_cnt_nxt (bit_cnt_nxt_s),
        .bclk        (AUD_BCLK),
        .lrck        (AUD_DACLRCK)
    );

    assign in_pair_s = {lsound_in, rsound_in};

    // Holding/shadow register control: frame load, bypass, underrun, accept.
    always_comb begin
        hold_nxt_s        = hold_r;
        hold_empty_nxt_s  = hold_empty_r;
        shadow_nxt_s      = shadow_r;
        frame_start_nxt_s = 1'b0;
        underrun_nxt_s    = 1'b0;
        if (frame_wrap_s) begin
            frame_start_nxt_s = 1'b1;
            if (!hold_empty_r) begin
                shadow_nxt_s     = hold_r;
                hold_empty_nxt_s = 1'b1;
            end else if (sample_valid) begin
                // Sample arriving on the load cycle goes straight to the shadow.
                shadow_nxt_s = in_pair_s;
            end else begin
                underrun_nxt_s = 1'b1;
            end
        end else if (sample_valid && hold_empty_r) begin
            hold_nxt_s       = in_pair_s;
            hold_empty_nxt_s = 1'b0;
        end else begin
            hold_nxt_s       = hold_r;
            hold_empty_nxt_s = hold_empty_r;
        end
    end

    // Decode the upcoming bit position into channel and slot position.
    always_comb begin
        if (bit_cnt_nxt_s >= BIT_W'(SLOT_BITS)) begin
            chan_s = CHAN_RIGHT;
            pos_s  = POS_W'(bit_cnt_nxt_s - BIT_W'(SLOT_BITS));
        end else begin
            chan_s = CHAN_LEFT;
            pos_s  = POS_W'(bit_cnt_nxt_s);
        end
    end

    // Serial data for the upcoming bit; only changes on BCLK falling edges.
    always_comb begin
        idx_s        = POS_W'(AUD_BIT_DEPTH) - pos_s;
        chan_word_s  = shadow_r.left;
        dacdat_nxt_s = dacdat_r;
        case (chan_s)
            CHAN_LEFT:  chan_word_s = shadow_r.left;
            CHAN_RIGHT: chan_word_s = shadow_r.right;
            default:    chan_word_s = shadow_r.left;
        endcase
        if (fall_s) begin
            if (slot_bit_active(int'(pos_s), AUD_BIT_DEPTH)) begin
                dacdat_nxt_s = chan_word_s[idx_s];
            end else begin
                dacdat_nxt_s = 1'b0;
            end
        end else begin
            dacdat_nxt_s = dacdat_r;
        end
    end

    // Buffer, serial data and status pulse registers.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            hold_r        <= sample_pair_t'({(2*AUD_BIT_DEPTH){1'b0}});
            shadow_r      <= sample_pair_t'({(2*AUD_BIT_DEPTH){1'b0}});
            hold_empty_r  <= 1'b1;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
            dacdat_r      <= 1'b0;
        end else begin
            hold_r        <= hold_nxt_s;
            shadow_r      <= shadow_nxt_s;
            hold_empty_r  <= hold_empty_nxt_s;
            frame_start_r <= frame_start_nxt_s;
            underrun_r    <= underrun_nxt_s;
            dacdat_r      <= dacdat_nxt_s;
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_r;

    // Saturating count of frames that started with the holding register empty.
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_data) begin
            underrun_cnt_r <= 16'h0000;
        end else if (underrun_nxt_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'h0001;
        end
    end

    assign underrun_cnt = underrun_cnt_r;
`else
    assign underrun_cnt = 16'h0000;
`endif

    assign sample_ready = hold_empty_r;
    assign AUD_DACDAT   = dacdat_r;
    assign frame_start  = frame_start_r;
    assign underrun     = underrun_r;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx. Expected outputs come from a
// cycle-count model: clock levels are arithmetic on the cycle number since
// reset release, and serial data is looked up from the sample the model
// believes is playing in the current frame.
module tb_audio_i2s_tx;

    localparam int W     = 24;
    localparam int SLOT  = 32;
    localparam int DIV   = 4;
    localparam int FRAME = 2 * SLOT * DIV;

    logic          clk = 1'b0;
    logic          reset_data;
    logic [W-1:0]  lsound_in;
    logic [W-1:0]  rsound_in;
    logic          sample_valid;
    logic          sample_ready;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          frame_start;
    logic          underrun;
    logic [15:0]   underrun_cnt;

    int            checks   = 0;
    int            failures = 0;

    // model state
    int            cyc;
    logic          hold_full;
    logic [2*W-1:0] hold_m;
    logic [2*W-1:0] play_m;
    logic [15:0]   ucnt_m;
    logic          fs_m;
    logic          ur_m;
    logic          acc_evt;

    always #5 clk = ~clk;

    audio_i2s_tx dut (
        .AUDIO_CLK    (clk),
        .reset_data   (reset_data),
        .lsound_in    (lsound_in),
        .rsound_in    (rsound_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    function automatic logic exp_dat(input int c, input logic [2*W-1:0] pl);
        int b;
        int p;
        logic [W-1:0] s;
        b = (c / DIV) % (2 * SLOT);
        p = b % SLOT;
        s = (b >= SLOT) ? pl[W-1:0] : pl[2*W-1:W];
        if (p >= 1 && p <= W) return s[W-p];
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: update the model for the coming edge, then check all outputs.
    task automatic step();
        logic [2*W-1:0] in_s;
        in_s    = {lsound_in, rsound_in};
        acc_evt = 1'b0;
        fs_m    = 1'b0;
        ur_m    = 1'b0;
        if (reset_data) begin
            cyc = 0; hold_full = 1'b0; play_m = '0; ucnt_m = 16'h0000;
        end else begin
            cyc++;
            if (cyc % FRAME == 0) begin
                fs_m = 1'b1;
                if (hold_full) begin
                    play_m = hold_m; hold_full = 1'b0;
                end else if (sample_valid) begin
                    play_m = in_s; acc_evt = 1'b1;
                end else begin
                    ur_m = 1'b1;
                    if (ucnt_m != 16'hFFFF) ucnt_m = ucnt_m + 16'h0001;
                end
            end else if (sample_valid && !hold_full) begin
                hold_m = in_s; hold_full = 1'b1; acc_evt = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("bclk",         32'(AUD_BCLK),     32'((cyc % DIV) >= DIV / 2));
        chk("lrck",         32'(AUD_DACLRCK),  32'((cyc % FRAME) >= FRAME / 2));
        chk("dacdat",       32'(AUD_DACDAT),   32'(exp_dat(cyc, play_m)));
        chk("frame_start",  32'(frame_start),  32'(fs_m));
        chk("underrun",     32'(underrun),     32'(ur_m));
        chk("sample_ready", 32'(sample_ready), 32'(!hold_full));
`ifdef I2S_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'(ucnt_m));
`else
        chk("underrun_cnt", 32'(underrun_cnt), 32'(0));
`endif
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the cycle count reaches position t within a frame.
    task automatic run_until(input int t);
        for (int i = 0; i <= FRAME; i++) begin
            step();
            if (cyc % FRAME == t) break;
        end
    endtask

    // Present a sample and hold it until the model sees it accepted.
    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        lsound_in    = l;
        rsound_in    = r;
        sample_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (acc_evt) break;
        end
        chk("accept_within_bound", 32'(acc_evt), 32'(1));
        sample_valid = 1'b0;
    endtask

    initial begin
        reset_data   = 1'b1;
        sample_valid = 1'b0;
        lsound_in    = '0;
        rsound_in    = '0;
        cyc = 0; hold_full = 1'b0; hold_m = '0; play_m = '0;
        ucnt_m = 16'h0000; fs_m = 1'b0; ur_m = 1'b0; acc_evt = 1'b0;
        @(negedge clk);

        // reset held three cycles
        run_cycles(3);
        chk("reset_ready", 32'(sample_ready), 32'(1));
        chk("reset_dat",   32'(AUD_DACDAT),   32'(0));
        reset_data = 1'b0;

        // known pattern, then two random samples (second waits on full hold)
        send(24'hA5A5A5, 24'h5A5A5A);
        run_until(0);
        chk("frame_start_a5", 32'(frame_start), 32'(1));
        run_cycles(30);
        send(24'($urandom()), 24'($urandom()));
        send(24'($urandom()), 24'($urandom()));

        // random samples at random points within frames
        for (int k = 0; k < 3; k++) begin
            run_until(int'($urandom_range(10, 200)));
            send(24'($urandom()), 24'($urandom()));
        end

        // starve the hold for one full frame after a known sample
        run_until(5);
        send(24'h000001, 24'($urandom()));
        run_until(0);
        run_until(0);
        chk("underrun_pulse", 32'(underrun), 32'(1));
`ifdef I2S_UNDERRUN_CNT_EN
        chk("underrun_cnt_one", 32'(underrun_cnt), 32'(1));
`else
        chk("underrun_cnt_zero", 32'(underrun_cnt), 32'(0));
`endif
        step();
        chk("underrun_single", 32'(underrun), 32'(0));

        // valid exactly on the frame-load cycle with the hold empty
        run_until(FRAME - 1);
        lsound_in    = 24'h800000;
        rsound_in    = 24'($urandom());
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("bypass_no_underrun", 32'(underrun),     32'(0));
        chk("bypass_ready",       32'(sample_ready), 32'(1));
        run_until(5);
        chk("bypass_msb", 32'(AUD_DACDAT), 32'(1));

        // reset in the middle of the right slot (bit 40)
        run_until(160);
        reset_data = 1'b1;
        step();
        chk("midrst_lrck",  32'(AUD_DACLRCK),  32'(0));
        chk("midrst_ready", 32'(sample_ready), 32'(1));
        reset_data = 1'b0;
        run_cycles(FRAME + 20);
        send(24'($urandom()), 24'($urandom()));
        run_until(0);
        run_cycles(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
